// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite encodings for the peripheral slaves and the single-transfer master,
// plus the master's data-phase state type.
package peripheral_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Non-cacheable, non-bufferable, privileged data access.
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef enum logic [1:0] {
    D_NONE   = 2'd0,
    D_ACTIVE = 2'd1,
    D_CANCEL = 2'd2
  } ahb3_master_dstate_t;

endpackage

// File: rtl/peripheral_master_ahb3.sv
// AHB3-Lite single-transfer master: valid/ready commands in, pipelined address/data phases out.
// Optional PERIPHERAL_AHB3_MASTER_ALIGN_CHECK_EN answers misaligned commands with an error instead of issuing them.
module peripheral_master_ahb3
  import peripheral_ahb3_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  // Command: transferred on the rising edge where cmd_valid & cmd_ready; the command
  // fields must stay stable while cmd_valid is high. Response: rsp_valid is a single-cycle
  // pulse with no backpressure, one per command, in command order.
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [HDATA_SIZE-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output ahb3_master_dstate_t   dstate
);

  logic                  a_valid;   // a command owns the address slot (issued or held)
  logic                  a_bad;     // that command is misaligned and is never driven as NONSEQ
  logic [HDATA_SIZE-1:0] a_wdata;
  logic                  d_write;
  logic                  d_bad;
  logic                  cmd_bad;
  logic                  first_err;
  logic                  cancel;
  logic                  accept;
  logic                  addr_done;

`ifdef PERIPHERAL_AHB3_MASTER_ALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [HADDR_SIZE-1:0] addr,
                                         input logic [2:0]            size);
    logic [HADDR_SIZE-1:0] mask;
    mask = (HADDR_SIZE'(1) << size) - HADDR_SIZE'(1);
    return (addr & mask) != '0;
  endfunction
  assign cmd_bad = is_misaligned(cmd_addr, cmd_size);
`else
  assign cmd_bad = 1'b0;
`endif

  assign first_err = (dstate == D_ACTIVE) && !HREADY && HRESP;
  assign cancel    = first_err || (dstate == D_CANCEL);
  assign cmd_ready = HRESETn && !cancel && (!a_valid || HREADY);
  assign accept    = cmd_valid && cmd_ready;
  // While cancelling, the held command is on the bus as IDLE, so HREADY does not retire it.
  assign addr_done = a_valid && HREADY && (dstate != D_CANCEL);

  assign HSEL      = (HTRANS == HTRANS_NONSEQ);
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA_PRIV;
  assign HMASTLOCK = 1'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid   <= 1'b0;
      a_bad     <= 1'b0;
      a_wdata   <= '0;
      HTRANS    <= HTRANS_IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= 3'b000;
      HWDATA    <= '0;
      d_write   <= 1'b0;
      d_bad     <= 1'b0;
      dstate    <= D_NONE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      // Address slot
      if (first_err) begin
        HTRANS <= HTRANS_IDLE;
      end else if (dstate == D_CANCEL) begin
        if (HREADY && a_valid && !a_bad) HTRANS <= HTRANS_NONSEQ;
      end else if (accept) begin
        a_valid <= 1'b1;
        a_bad   <= cmd_bad;
        a_wdata <= cmd_wdata;
        if (cmd_bad) begin
          HTRANS <= HTRANS_IDLE;
        end else begin
          HTRANS <= HTRANS_NONSEQ;
          HADDR  <= cmd_addr;
          HWRITE <= cmd_write;
          HSIZE  <= cmd_size;
        end
      end else if (addr_done) begin
        a_valid <= 1'b0;
        a_bad   <= 1'b0;
        HTRANS  <= HTRANS_IDLE;
      end

      // Data phase
      case (dstate)
        D_NONE: begin
          if (addr_done) begin
            dstate  <= D_ACTIVE;
            d_write <= HWRITE;
            d_bad   <= a_bad;
            HWDATA  <= a_wdata;
          end
        end
        D_ACTIVE: begin
          if (HREADY) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= (d_write || d_bad) ? '0 : HRDATA;
            rsp_error <= HRESP || d_bad;
            if (addr_done) begin
              d_write <= HWRITE;
              d_bad   <= a_bad;
              HWDATA  <= a_wdata;
            end else begin
              dstate <= D_NONE;
            end
          end else if (HRESP) begin
            dstate <= D_CANCEL;
          end
        end
        D_CANCEL: begin
          if (HREADY) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= d_write ? '0 : HRDATA;
            rsp_error <= 1'b1;
            dstate    <= D_NONE;
          end
        end
        default: dstate <= D_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_master_ahb3.sv
// Bench for peripheral_master_ahb3: reactive AHB slave model, command driver, and a response
// scoreboard that checks order, data, error flag and (where fixed) latency.
module tb_peripheral_master_ahb3;
  import peripheral_ahb3_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 50;  // {check_lat, due_cycle[15:0], error, rdata[31:0]}

  logic                HCLK = 1'b0;
  logic                HRESETn = 1'b0;
  logic                cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]       cmd_addr;
  logic [2:0]          cmd_size;
  logic [DW-1:0]       cmd_wdata;
  logic                rsp_valid, rsp_error;
  logic [DW-1:0]       rsp_rdata;
  logic                HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [AW-1:0]       HADDR;
  logic [2:0]          HSIZE, HBURST;
  logic [3:0]          HPROT;
  logic [1:0]          HTRANS;
  logic [DW-1:0]       HWDATA, HRDATA;
  ahb3_master_dstate_t dstate;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] wexp_q[$];

  int          cfg_waits = 0;
  bit          cfg_rand = 1'b0;
  bit          cfg_err_en = 1'b0;
  logic [31:0] cfg_err_addr = '0;

  peripheral_master_ahb3 #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .dstate(dstate)
  );

  // Clock and cycle counter
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    if (a == 32'h14) return 32'h1234_5678;
    return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
  endfunction

  // Slave model: drives HREADY/HRESP/HRDATA at negedge for the upcoming edge
  initial begin : slave
    bit          in_data, d_wr, d_err, err_ph, p_ready, p_nonseq, p_write;
    int          cnt;
    logic [31:0] d_addr, p_addr, wexp;
    in_data = 0; d_wr = 0; d_err = 0; err_ph = 0; cnt = 0; d_addr = '0;
    p_ready = 1; p_nonseq = 0; p_write = 0; p_addr = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        in_data = 0; p_ready = 1; p_nonseq = 0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      end else begin
        if (p_ready) begin
          in_data = p_nonseq;
          if (p_nonseq) begin
            d_addr = p_addr;
            d_wr   = p_write;
            cnt    = cfg_rand ? int'($urandom_range(0, 2)) : cfg_waits;
            d_err  = cfg_err_en && (p_addr == cfg_err_addr);
            if (d_err) cfg_err_en = 1'b0;
            err_ph = 0;
          end
        end
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        if (in_data) begin
          if (cnt > 0) begin
            HREADY = 1'b0;
            cnt--;
          end else if (d_err && !err_ph) begin
            HREADY = 1'b0; HRESP = 1'b1; err_ph = 1;
          end else if (d_err) begin
            HRESP = 1'b1;
          end else if (!d_wr) begin
            HRDATA = rdata_for(d_addr);
          end
          if (HREADY && d_wr) begin
            if (wexp_q.size() == 0) check("hwdata_q", 64'(wexp_q.size()), 64'd1);
            else begin
              wexp = wexp_q.pop_front();
              check("hwdata", 64'(HWDATA), 64'(wexp));
            end
          end
        end
        p_ready  = HREADY;
        p_nonseq = (HTRANS == HTRANS_NONSEQ);
        p_addr   = HADDR;
        p_write  = HWRITE;
      end
    end
  end

  // Response scoreboard
  initial begin : monitor
    logic [EW-1:0] e;
    forever begin
      @(negedge HCLK);
      if (HRESETn && rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_spurious", 64'(rsp_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("rsp_error", 64'(rsp_error), 64'(e[32]));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
          if (e[49]) check("rsp_latency", 64'(cyc[15:0]), 64'(e[48:33]));
        end
      end
    end
  end

  // Driver: returns 1 time unit after the accepting edge
  task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, input int lat, input bit bad,
                          output int waited);
    bit          ok;
    logic        err;
    logic [31:0] rd;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
    waited = 0;
    ok = 0;
    while (!ok && waited < 50) begin
      @(posedge HCLK);
      waited++;
      ok = cmd_ready;
    end
    #1;
    cmd_valid = 1'b0;
    if (!ok) begin
      check("cmd_accept", 64'(cmd_ready), 64'd1);
      return;
    end
    err = bad || (cfg_err_en && addr == cfg_err_addr);
    rd  = (wr || err) ? 32'h0 : rdata_for(addr);
    exp_q.push_back({lat != 0, 16'(cyc + lat), err, rd});
    if (wr && !bad) wexp_q.push_back(wdata);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge HCLK);
      #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge HCLK);
    #1;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  initial begin : main
    int w;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;

    // Reset values
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
    check("rst_hsel", 64'(HSEL), 64'd0);
    check("rst_haddr", 64'(HADDR), 64'd0);
    check("rst_hwrite", 64'(HWRITE), 64'd0);
    check("rst_hsize", 64'(HSIZE), 64'd0);
    check("rst_hburst", 64'(HBURST), 64'd0);
    check("rst_hprot", 64'(HPROT), 64'h3);
    check("rst_hmastlock", 64'(HMASTLOCK), 64'd0);
    check("rst_hwdata", 64'(HWDATA), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_error, rsp_rdata}), 64'd0);
    check("rst_dstate", 64'(dstate), 64'(D_NONE));
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();

    // Zero-wait write
    send_cmd(1'b1, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF, 2, 1'b0, w);
    check("w_htrans", 64'(HTRANS), 64'(HTRANS_NONSEQ));
    check("w_hsel", 64'(HSEL), 64'd1);
    check("w_haddr", 64'(HADDR), 64'h10);
    check("w_hwrite", 64'(HWRITE), 64'd1);
    check("w_hsize", 64'(HSIZE), 64'(HSIZE_WORD));
    step();
    check("w_idle", 64'(HTRANS), 64'(HTRANS_IDLE));
    check("w_hsel_idle", 64'(HSEL), 64'd0);
    check("w_hwdata", 64'(HWDATA), 64'hDEAD_BEEF);
    check("w_dstate", 64'(dstate), 64'(D_ACTIVE));
    check("w_haddr_hold", 64'(HADDR), 64'h10);
    drain();

    // Read with three wait states
    cfg_waits = 3;
    send_cmd(1'b0, 32'h14, HSIZE_WORD, 32'h0, 5, 1'b0, w);
    drain();
    cfg_waits = 0;

    // Back-to-back writes
    for (int i = 0; i < 4; i++) begin
      send_cmd(1'b1, 32'(i * 4), HSIZE_WORD, $urandom, 2, 1'b0, w);
      check("b2b_wait", 64'(w), 64'd1);
      check("b2b_htrans", 64'(HTRANS), 64'(HTRANS_NONSEQ));
      check("b2b_haddr", 64'(HADDR), 64'(i * 4));
    end
    drain();

    // Error on a pipelined write, read behind it is re-issued
    cfg_err_en = 1'b1;
    cfg_err_addr = 32'h8;
    send_cmd(1'b1, 32'h8, HSIZE_WORD, 32'hA5A5_0008, 3, 1'b0, w);
    send_cmd(1'b0, 32'hC, HSIZE_WORD, 32'h0, 4, 1'b0, w);
    check("e_haddr", 64'(HADDR), 64'hC);
    check("e_dstate_act", 64'(dstate), 64'(D_ACTIVE));
    step();
    check("e_htrans_idle", 64'(HTRANS), 64'(HTRANS_IDLE));
    check("e_hsel_idle", 64'(HSEL), 64'd0);
    check("e_dstate_cancel", 64'(dstate), 64'(D_CANCEL));
    check("e_haddr_hold", 64'(HADDR), 64'hC);
    check("e_cmd_ready", 64'(cmd_ready), 64'd0);
    step();
    check("e_reissue", 64'(HTRANS), 64'(HTRANS_NONSEQ));
    check("e_reissue_addr", 64'(HADDR), 64'hC);
    check("e_dstate_none", 64'(dstate), 64'(D_NONE));
    drain();
    cfg_err_en = 1'b0;

`ifdef PERIPHERAL_AHB3_MASTER_ALIGN_CHECK_EN
    // Misaligned read is answered with an error and never issued
    send_cmd(1'b0, 32'h2, HSIZE_WORD, 32'h0, 2, 1'b1, w);
    check("al_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
    check("al_hsel", 64'(HSEL), 64'd0);
    step();
    check("al_htrans2", 64'(HTRANS), 64'(HTRANS_IDLE));
    drain();
`endif

    // Random mix with random wait states and gaps
    cfg_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) step();
      send_cmd(1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
               HSIZE_WORD, $urandom, 0, 1'b0, w);
    end
    drain();
    cfg_rand = 1'b0;

    // Reset during a wait-stated data phase
    cfg_waits = 10;
    send_cmd(1'b0, 32'h20, HSIZE_WORD, 32'h0, 0, 1'b0, w);
    repeat (3) @(posedge HCLK);
    #3;
    HRESETn = 1'b0;
    #1;
    check("mr_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
    check("mr_hsel", 64'(HSEL), 64'd0);
    check("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mr_cmd_ready", 64'(cmd_ready), 64'd0);
    check("mr_dstate", 64'(dstate), 64'(D_NONE));
    check("mr_haddr", 64'(HADDR), 64'd0);
    exp_q.delete();
    cfg_waits = 0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (10) step();
    send_cmd(1'b1, 32'h30, HSIZE_WORD, 32'h0BAD_F00D, 2, 1'b0, w);
    drain();

    check("end_exp_q", 64'(exp_q.size()), 64'd0);
    check("end_wexp_q", 64'(wexp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
